// File: rtl/unidad_condicional.sv
// unidad_condicional: NZCV flag register, ARM condition evaluation and a gated
// one-entry valid/ready output register feeding the memory/writeback stage.
module unidad_condicional #(
  parameter int N  = 32,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    cond,
  input  logic [1:0]    flag_write,
  input  logic          reg_write,
  input  logic          mem_write,
  input  logic          pc_src,
  input  logic [N-1:0]  resultado,
  input  logic          flagNegativo,
  input  logic          flagCero,
  input  logic          flagCarry,
  input  logic          flagOverflow,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_resultado,
  output logic          out_reg_write,
  output logic          out_mem_write,
  output logic          out_pc_src,
  output logic          out_cond_ex,
  output logic [3:0]    nzcv,
  output logic [CW-1:0] cuenta_anuladas
);
  logic          r_valid;
  logic [N-1:0]  r_resultado;
  logic          r_reg_write;
  logic          r_mem_write;
  logic          r_pc_src;
  logic          r_cond_ex;
  logic [3:0]    r_nzcv;
  logic [CW-1:0] r_cuenta;
  logic          w_n, w_z, w_c, w_v, w_ge;
  logic [15:0]   w_tabla;
  logic          w_cond_ex;
  logic          w_accept;
  assign {w_n, w_z, w_c, w_v} = r_nzcv;
  assign w_ge = (w_n == w_v);
  // one bit per condition code, index = cond (F is never, E is always)
  assign w_tabla = {1'b0, 1'b1, w_z | ~w_ge, ~w_z & w_ge, ~w_ge, w_ge,
                    w_z | ~w_c, w_c & ~w_z, ~w_v, w_v, ~w_n, w_n,
                    ~w_c, w_c, ~w_z, w_z};
  assign w_cond_ex = w_tabla[cond];
  assign in_ready  = ~flush & (~r_valid | out_ready);
  assign w_accept  = in_valid & in_ready;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid     <= 1'b0;
      r_resultado <= '0;
      r_reg_write <= 1'b0;
      r_mem_write <= 1'b0;
      r_pc_src    <= 1'b0;
      r_cond_ex   <= 1'b0;
      r_nzcv      <= 4'b0000;
      r_cuenta    <= '0;
    end else begin
      if (flush) begin
        r_valid     <= 1'b0;
        r_reg_write <= 1'b0;
        r_mem_write <= 1'b0;
        r_pc_src    <= 1'b0;
      end else if (w_accept) begin
        r_valid     <= 1'b1;
        r_resultado <= resultado;
        r_reg_write <= reg_write & w_cond_ex;
        r_mem_write <= mem_write & w_cond_ex;
        r_pc_src    <= pc_src & w_cond_ex;
        r_cond_ex   <= w_cond_ex;
      end else if (out_ready) begin
        r_valid <= 1'b0;
      end
      if (w_accept & w_cond_ex & flag_write[1]) r_nzcv[3:2] <= {flagNegativo, flagCero};
      if (w_accept & w_cond_ex & flag_write[0]) r_nzcv[1:0] <= {flagCarry, flagOverflow};
      if (w_accept & ~w_cond_ex & (r_cuenta != {CW{1'b1}})) r_cuenta <= r_cuenta + 1'b1;
    end
  end
  assign out_valid       = r_valid;
  assign out_resultado   = r_resultado;
  assign out_reg_write   = r_reg_write;
  assign out_mem_write   = r_mem_write;
  assign out_pc_src      = r_pc_src;
  assign out_cond_ex     = r_cond_ex;
  assign nzcv            = r_nzcv;
  assign cuenta_anuladas = r_cuenta;
endmodule

// File: tb/tb_unidad_condicional.sv
// tb_unidad_condicional: scoreboard bench with a flag/condition reference model;
// a second 3-bit-counter instance exercises counter saturation cheaply.
module tb_unidad_condicional;
  localparam int N = 32;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic         rst_n = 1'b0, in_valid = 1'b0, in_ready, reg_write = 1'b0, mem_write = 1'b0, pc_src = 1'b0;
  logic [3:0]   cond = 4'hE;
  logic [1:0]   flag_write = 2'b00;
  logic [N-1:0] resultado = '0;
  logic         fn = 1'b0, fz = 1'b0, fc = 1'b0, fv = 1'b0, flush = 1'b0, out_ready = 1'b1;
  logic         out_valid, out_reg_write, out_mem_write, out_pc_src, out_cond_ex;
  logic [N-1:0] out_resultado;
  logic [3:0]   nzcv;
  logic [15:0]  cuenta_anuladas;
  logic         s_in_ready, s_valid, s_rw, s_mw, s_pc, s_cex;
  logic [N-1:0] s_res;
  logic [3:0]   s_nzcv;
  logic [2:0]   s_cuenta;

  unidad_condicional #(.N(N), .CW(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .cond(cond),
    .flag_write(flag_write), .reg_write(reg_write), .mem_write(mem_write), .pc_src(pc_src),
    .resultado(resultado), .flagNegativo(fn), .flagCero(fz), .flagCarry(fc), .flagOverflow(fv),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_resultado(out_resultado),
    .out_reg_write(out_reg_write), .out_mem_write(out_mem_write), .out_pc_src(out_pc_src),
    .out_cond_ex(out_cond_ex), .nzcv(nzcv), .cuenta_anuladas(cuenta_anuladas));

  unidad_condicional #(.N(N), .CW(3)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready), .cond(cond),
    .flag_write(flag_write), .reg_write(reg_write), .mem_write(mem_write), .pc_src(pc_src),
    .resultado(resultado), .flagNegativo(fn), .flagCero(fz), .flagCarry(fc), .flagOverflow(fv),
    .flush(flush), .out_valid(s_valid), .out_ready(out_ready), .out_resultado(s_res),
    .out_reg_write(s_rw), .out_mem_write(s_mw), .out_pc_src(s_pc),
    .out_cond_ex(s_cex), .nzcv(s_nzcv), .cuenta_anuladas(s_cuenta));

  int errs = 0, checks = 0;
  logic [N+3:0] q[$];
  logic         m_valid = 1'b0, n_valid = 1'b0, exp_rdy = 1'b1;
  logic [3:0]   m_nzcv = '0, n_nzcv = '0;
  int           m_cnt = 0, n_cnt = 0, m_cnt_s = 0, n_cnt_s = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit pasa(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cc, v;
    {n, z, cc, v} = f;
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cc;
      4'h3: return !cc;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cc && !z;
      4'h9: return !cc || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // one cycle of stimulus: commit the model for the edge just taken, apply new inputs
  task automatic step(input logic v, input logic [3:0] c, input logic [1:0] fw, input logic rw,
                      input logic mw, input logic pc, input logic [N-1:0] r, input logic [3:0] f,
                      input logic fl, input logic ordy);
    bit acc, pass;
    @(posedge clk); #2;
    m_valid = n_valid; m_nzcv = n_nzcv; m_cnt = n_cnt; m_cnt_s = n_cnt_s;
    in_valid = v; cond = c; flag_write = fw; reg_write = rw; mem_write = mw; pc_src = pc;
    resultado = r; {fn, fz, fc, fv} = f; flush = fl; out_ready = ordy;
    exp_rdy = !fl && (!m_valid || ordy);
    acc = v && exp_rdy;
    pass = pasa(c, m_nzcv);
    n_valid = fl ? 1'b0 : acc ? 1'b1 : (m_valid && ordy) ? 1'b0 : m_valid;
    if (acc) begin
      q.push_back({r, rw && pass, mw && pass, pc && pass, pass});
      if (pass) begin
        if (fw[1]) n_nzcv[3:2] = f[3:2];
        if (fw[0]) n_nzcv[1:0] = f[1:0];
      end else begin
        n_cnt   = (n_cnt < 65535) ? n_cnt + 1 : n_cnt;
        n_cnt_s = (n_cnt_s < 7) ? n_cnt_s + 1 : n_cnt_s;
      end
    end
  endtask

  task automatic reset_dut();
    @(posedge clk); #2;
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    @(posedge clk); #2;
    rst_n = 1'b1; exp_rdy = 1'b1;
    m_valid = 0; n_valid = 0; m_nzcv = 0; n_nzcv = 0; m_cnt = 0; n_cnt = 0; m_cnt_s = 0; n_cnt_s = 0;
    q.delete();
  endtask

  task automatic idle();
    step(1'b0, 4'hE, 2'b00, 1'b0, 1'b0, 1'b0, '0, 4'h0, 1'b0, 1'b1);
  endtask

  // monitor: compares the presented entry against the scoreboard every cycle it is held
  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", in_ready, exp_rdy);
      chk("out_valid", out_valid, m_valid);
      chk("nzcv", nzcv, m_nzcv);
      chk("cuenta", cuenta_anuladas, m_cnt);
      chk("cuenta_sat3", s_cuenta, m_cnt_s);
      if (m_valid) begin
        if (q.size() == 0) begin
          errs++; checks++;
          $display("FAIL scoreboard: DUT presents entry %0h but none expected", out_resultado);
        end else begin
          chk("salida", {out_resultado, out_reg_write, out_mem_write, out_pc_src, out_cond_ex}, q[0]);
          if (out_ready || flush) void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    reset_dut();
    @(negedge clk);
    chk("reset_valid", out_valid, 0);
    chk("reset_nzcv", nzcv, 0);
    chk("reset_res", {out_resultado, out_reg_write, out_mem_write, out_pc_src, out_cond_ex}, 0);
    // ADDS with zero result
    step(1, 4'hE, 2'b11, 1, 0, 0, 32'd0, 4'b0100, 0, 1);
    step(1, 4'h0, 2'b00, 1, 0, 0, 32'd5, 4'b0000, 0, 1);
    @(negedge clk);
    chk("adds_nzcv", nzcv, 4'b0100);
    chk("adds_rw", out_reg_write, 1);
    step(1, 4'h1, 2'b00, 1, 0, 0, 32'd6, 4'b0000, 0, 1);
    @(negedge clk);
    chk("eq_rw", out_reg_write, 1);
    idle();
    @(negedge clk);
    chk("ne_rw", out_reg_write, 0);
    chk("ne_cnt", cuenta_anuladas, 1);
    chk("ne_nzcv", nzcv, 4'b0100);
    // CMP sets N=1,V=1 then GE/LT back to back
    step(1, 4'hE, 2'b11, 0, 0, 0, 32'd7, 4'b1001, 0, 1);
    step(1, 4'hA, 2'b00, 1, 0, 0, 32'd8, 4'b0000, 0, 1);
    step(1, 4'hB, 2'b00, 1, 0, 0, 32'd9, 4'b0000, 0, 1);
    @(negedge clk);
    chk("ge_pass", out_cond_ex, 1);
    chk("lt_no_bubble", in_ready, 1);
    idle();
    @(negedge clk);
    chk("lt_fail", out_cond_ex, 0);
    chk("lt_cnt", cuenta_anuladas, 2);
    // downstream stall
    for (int i = 0; i < 4; i++) step(1, 4'hE, 2'b11, 1, 0, 0, 32'd100 + i, 4'b0110, 0, 0);
    @(negedge clk);
    chk("stall_res", out_resultado, 32'd100);
    chk("stall_rdy", in_ready, 0);
    chk("stall_nzcv", nzcv, 4'b0110);
    // flush while full and a new instruction is offered
    step(1, 4'hE, 2'b11, 1, 1, 1, 32'd200, 4'b1111, 1, 0);
    idle();
    @(negedge clk);
    chk("flush_valid", out_valid, 0);
    chk("flush_nzcv", nzcv, 4'b0110);
    // never-condition instructions saturate the 3-bit counter
    for (int i = 0; i < 9; i++) step(1, 4'hF, 2'b11, 1, 1, 1, 32'd300 + i, 4'b1111, 0, 1);
    idle();
    @(negedge clk);
    chk("sat_cnt3", s_cuenta, 3'd7);
    chk("nv_gated", {out_cond_ex, out_reg_write, out_mem_write, out_pc_src}, 4'b0000);
    chk("nv_cnt16", cuenta_anuladas, 16'd11);
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 1500; i++)
        step($urandom_range(3) != 0, 4'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
             1'($urandom), $urandom, 4'($urandom), $urandom_range(15) == 0, $urandom_range(3) != 0);
      if (k == 0) reset_dut();
    end
    for (int i = 0; i < 3; i++) idle();
    @(negedge clk);
    chk("drain_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/unidad_condicional.md
Name: unidad_condicional

Overview:
- Stage directly downstream of unidad_logico_aritmetica.
- Holds the architectural NZCV flag register and evaluates the ARM condition field of each instruction against it.
- Gates register, memory and PC writes for instructions whose condition fails.
- Registers the ALU result plus gated controls into a one-entry valid/ready pipeline register feeding the memory/writeback stage.

Parameters:
- N, 32, width of the ALU result path (matches the ALU N).
- CW, 16, width of the saturating condition-failed counter.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  ALU stage presents a valid instruction.
- in_ready  out  1  this stage accepts this cycle.
- cond  in  4  ARM condition field, instr[31:28].
- flag_write  in  2  bit1 updates N,Z; bit0 updates C,V.
- reg_write  in  1  instruction writes the register file.
- mem_write  in  1  instruction writes memory.
- pc_src  in  1  instruction writes the PC (branch or R15 destination).
- resultado  in  N  ALU resultadoFinal.
- flagNegativo, flagCero, flagCarry, flagOverflow  in  1 each  ALU flags for this instruction.
- flush  in  1  squash the output register (branch taken downstream).
- out_valid  out  1  output register holds an instruction.
- out_ready  in  1  downstream accepts.
- out_resultado  out  N  registered result.
- out_reg_write, out_mem_write, out_pc_src  out  1 each  registered controls, already gated by the condition.
- out_cond_ex  out  1  registered condition-passed bit.
- nzcv  out  4  current flag register {N,Z,C,V}.
- cuenta_anuladas  out  CW  saturating count of condition-failed accepted instructions.

Behaviour:
- Reset (rst_n=0 at edge): out_valid=0, nzcv=4'b0000, all out_* data and controls 0, cuenta_anuladas=0. Reset mid-transfer discards the held entry.
- cond_ex is combinational from cond and the current nzcv register, never the incoming ALU flags:
  - 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V.
  - 8 HI C&!Z; 9 LS !C|Z; A GE N==V; B LT N!=V; C GT !Z&(N==V); D LE Z|(N!=V).
  - E AL 1; F treated as never (0).
- in_ready = !flush & (!out_valid | out_ready).
- Accept = in_valid & in_ready. On accept, the next edge:
  - loads out_resultado and out_cond_ex.
  - sets out_reg_write=reg_write&cond_ex, out_mem_write=mem_write&cond_ex, out_pc_src=pc_src&cond_ex.
  - sets out_valid=1.
- Flag update on accept only when cond_ex=1: flag_write[1] loads N,Z from flagNegativo,flagCero; flag_write[0] loads C,V from flagCarry,flagOverflow. Otherwise nzcv holds.
- Latency: one cycle from accept to out_valid. The updated nzcv is visible to cond_ex of the next instruction in the following cycle, so back-to-back dependent instructions need no stall.
- Output register:
  - if out_valid & out_ready & no accept, out_valid becomes 0 next edge.
  - if out_valid & !out_ready, all out_* hold stable.
- Failed-condition instructions are still passed downstream (out_valid=1) with all write enables 0.
- cuenta_anuladas increments on each accept with cond_ex=0 and saturates at 2^CW-1 (no wrap).
- flush=1:
  - next edge out_valid=0 and out write enables=0.
  - no accept occurs that cycle (in_ready=0), so nzcv and the counter are unaffected.
  - flush has priority over out_ready and in_valid.
- Simultaneous out_ready=1 and accept: the old entry leaves and the new entry loads in the same edge (full throughput, 1 instr/cycle).

Test Plan:
- Reset, then ADDS giving resultado=0, flagCero=1, cond=E, flag_write=11 -> next cycle nzcv=0100, out_valid=1, out_reg_write=1.
- With nzcv=0100 send cond=0 (EQ) reg_write=1, then cond=1 (NE) reg_write=1 -> out_reg_write 1 then 0; cuenta_anuladas=1; nzcv unchanged.
- CMP setting nzcv=1001 (N=1,V=1), immediately followed by cond=A (GE) and cond=B (LT) -> GE passes, LT fails, with no bubble between them.
- Hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 after the first accept; out_resultado stays stable; nzcv and the counter do not change during the stall.
- Assert flush while in_valid=1 and out_valid=1 -> next cycle out_valid=0; incoming instruction not accepted; nzcv unchanged.
- Force cuenta_anuladas to 16'hFFFE, then send 3 failed-condition instructions -> counter reads FFFF and holds; cond=F -> out_cond_ex=0 and all gated write enables 0.
